// File: rtl/rom_fsm_stim_gen_if.sv
// Handshake and serial X/Z bundle for rom_fsm_stim_gen.
// The slave side is the stimulus engine; the master side is the host/bench,
// which also stands in for the ROM FSM by driving Z.
interface rom_fsm_stim_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             busy;
  logic             X;
  logic             Z;
  logic [WIDTH-1:0] dout;
  logic             done;

  modport master (output start, din, Z, input ready, busy, X, dout, done);
  modport slave  (input start, din, Z, output ready, busy, X, dout, done);
endinterface

// File: rtl/rom_fsm_stim_gen.sv
// Serial stimulus/response engine for ROM-table Mealy FSMs.
// Shifts a parallel word out on X one bit per cycle and captures the Mealy
// response Z into a parallel word, with a start/ready/done handshake.
// Build option: ROM_FSM_STIM_LSB_FIRST_EN selects LSB-first order
// (default MSB-first). Loopback of Z to X returns dout == din either way.
module rom_fsm_stim_gen #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  rom_fsm_stim_gen_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;   // stimulus bits not yet sent, next bit at the exit end
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] dout_r;
  logic [CW-1:0]    cnt;
  logic             x_r;
  logic             done_r;

  logic             last;
  logic             first_bit;
  logic             nxt_bit;
  logic [WIDTH-1:0] load_rem;
  logic [WIDTH-1:0] shreg_shift;
  logic [WIDTH-1:0] cap_nxt;

  assign last = (cnt == LAST);

`ifdef ROM_FSM_STIM_LSB_FIRST_EN
  // LSB-first: send din[0] first, Z enters at the top so loopback lines up
  assign first_bit   = bus.din[0];
  assign load_rem    = bus.din >> 1;
  assign nxt_bit     = shreg[0];
  assign shreg_shift = shreg >> 1;
  assign cap_nxt     = {bus.Z, cap[WIDTH-1:1]};
`else
  // MSB-first: send din[WIDTH-1] first, Z enters at the bottom
  assign first_bit   = bus.din[WIDTH-1];
  assign load_rem    = bus.din << 1;
  assign nxt_bit     = shreg[WIDTH-1];
  assign shreg_shift = shreg << 1;
  assign cap_nxt     = {cap[WIDTH-2:0], bus.Z};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accepted start, shift/capture in SHIFT, retire in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      cap    <= '0;
      dout_r <= '0;
      cnt    <= '0;
      x_r    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x_r <= 1'b0;
          if (bus.start) begin
            shreg <= load_rem;
            cnt   <= '0;
            cap   <= '0;
            x_r   <= first_bit;
          end
        end
        SHIFT: begin
          cap <= cap_nxt;
          if (last) begin
            dout_r <= cap_nxt;
            done_r <= 1'b1;
            x_r    <= 1'b0;
          end else begin
            x_r   <= nxt_bit;
            shreg <= shreg_shift;
            cnt   <= cnt + 1'b1;
          end
        end
        DONE:    done_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.X     = x_r;
  assign bus.dout  = dout_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_rom_fsm_stim_gen.sv
// Self-checking bench for rom_fsm_stim_gen. Z is produced by a selectable
// combinational response (loopback, inverted, tied 0, tied 1); expected
// X sequences and result words come from the word-level behaviour.
module tb_rom_fsm_stim_gen;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   zmode;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  rom_fsm_stim_gen_if #(.WIDTH(W)) bus ();

  assign bus.Z = (zmode == 0) ? bus.X :
                 (zmode == 1) ? ~bus.X :
                 (zmode == 2) ? 1'b0 : 1'b1;

  rom_fsm_stim_gen #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // observations from the last transfer
  logic [W-1:0] obs_x;
  logic [W-1:0] obs_dout;
  int           obs_ndone;
  int           obs_donec;
  logic         obs_ready;

  // order in which din bits should appear on X
  function automatic logic [W-1:0] exp_xseq(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
`ifdef ROM_FSM_STIM_LSB_FIRST_EN
      r[i] = d[i];
`else
      r[i] = d[W-1-i];
`endif
    end
    return r;
  endfunction

  // word-level result of each response mode
  function automatic logic [W-1:0] exp_dout(input logic [W-1:0] d, input int m);
    case (m)
      0:       return d;
      1:       return ~d;
      2:       return '0;
      default: return '1;
    endcase
  endfunction

  // One transfer: pulse start, then watch the W+2 cycles that follow.
  // repulse raises start with a different din while busy (SHIFT and DONE).
  task automatic run_xfer(input logic [W-1:0] d, input bit repulse);
    @(negedge clk); bus.din = d; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    if (repulse) bus.din = W'('h11);
    obs_ndone = 0; obs_donec = -1; obs_x = '0; obs_ready = 1'b0;
    for (int c = 0; c <= W + 1; c++) begin
      if (c < W) obs_x[c] = bus.X;
      if (bus.done) begin obs_ndone++; obs_donec = c; end
      if (c == W) obs_dout = bus.dout;
      if (c == W + 1) obs_ready = bus.ready;
      if (repulse) bus.start = (c == 1 || c == W);
      if (c < W + 1) @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.din = '0; zmode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.X !== 1'b0) $display("FAIL reset_x got=%b exp=0", bus.X); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.dout !== '0) $display("FAIL reset_dout got=%h exp=00", bus.dout); else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [W-1:0] d;
    d = W'('hA5);
    zmode = 0;
    run_xfer(d, 1'b0);
    total_cnt++; if (obs_x !== exp_xseq(d)) $display("FAIL loop_xseq got=%b exp=%b", obs_x, exp_xseq(d)); else pass_cnt++;
    total_cnt++; if (obs_donec !== W) $display("FAIL loop_done_latency got=%0d exp=%0d", obs_donec, W); else pass_cnt++;
    total_cnt++; if (obs_ndone !== 1) $display("FAIL loop_done_count got=%0d exp=1", obs_ndone); else pass_cnt++;
    total_cnt++; if (obs_dout !== d) $display("FAIL loop_dout got=%h exp=%h", obs_dout, d); else pass_cnt++;
    total_cnt++; if (obs_ready !== 1'b1) $display("FAIL loop_ready_after got=%b exp=1", obs_ready); else pass_cnt++;
    d = W'('h01);
    run_xfer(d, 1'b0);
    total_cnt++; if (obs_x !== exp_xseq(d)) $display("FAIL loop01_xseq got=%b exp=%b", obs_x, exp_xseq(d)); else pass_cnt++;
    total_cnt++; if (obs_dout !== d) $display("FAIL loop01_dout got=%h exp=%h", obs_dout, d); else pass_cnt++;
  endtask

  task automatic test_response_modes();
    zmode = 1;
    run_xfer(W'('h3C), 1'b0);
    total_cnt++; if (obs_dout !== W'('hC3)) $display("FAIL inv_dout got=%h exp=c3", obs_dout); else pass_cnt++;
    zmode = 2;
    run_xfer(W'('hFF), 1'b0);
    total_cnt++; if (obs_dout !== W'('h00)) $display("FAIL zero_dout got=%h exp=00", obs_dout); else pass_cnt++;
    zmode = 0;
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] d;
    d = W'('hA5);
    zmode = 0;
    run_xfer(d, 1'b1);
    total_cnt++; if (obs_x !== exp_xseq(d)) $display("FAIL busy_start_xseq got=%b exp=%b", obs_x, exp_xseq(d)); else pass_cnt++;
    total_cnt++; if (obs_dout !== d) $display("FAIL busy_start_dout got=%h exp=%h", obs_dout, d); else pass_cnt++;
    total_cnt++; if (obs_ndone !== 1) $display("FAIL busy_start_done_count got=%0d exp=1", obs_ndone); else pass_cnt++;
    total_cnt++; if (obs_ready !== 1'b1) $display("FAIL busy_start_ready got=%b exp=1", obs_ready); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    zmode = 0;
    @(negedge clk); bus.din = W'('hF0); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (bus.X !== 1'b0) $display("FAIL rst_x got=%b exp=0", bus.X); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.dout !== '0) $display("FAIL rst_dout got=%h exp=00", bus.dout); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < W + 2; c++) begin
        @(negedge clk);
        if (bus.done) nd++;
      end
      total_cnt++; if (nd !== 0) $display("FAIL rst_no_done got=%0d exp=0", nd); else pass_cnt++;
    end
    run_xfer(W'('h0F), 1'b0);
    total_cnt++; if (obs_dout !== W'('h0F)) $display("FAIL rst_next_dout got=%h exp=0f", obs_dout); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int n = 0; n < 12; n++) begin
      d = W'($urandom);
      zmode = int'($urandom_range(0, 3));
      run_xfer(d, 1'b0);
      total_cnt++; if (obs_x !== exp_xseq(d)) $display("FAIL rand_xseq[%0d] got=%b exp=%b", n, obs_x, exp_xseq(d)); else pass_cnt++;
      total_cnt++; if (obs_dout !== exp_dout(d, zmode)) $display("FAIL rand_dout[%0d] mode=%0d got=%h exp=%h", n, zmode, obs_dout, exp_dout(d, zmode)); else pass_cnt++;
      total_cnt++; if (obs_ndone !== 1 || obs_donec !== W) $display("FAIL rand_done[%0d] got=%0d@%0d exp=1@%0d", n, obs_ndone, obs_donec, W); else pass_cnt++;
    end
    zmode = 0;
  endtask

  task automatic test_back_to_back();
    int dcyc[$];
    logic [W-1:0] d;
    logic [W-1:0] douts[$];
    d = W'('h5B);
    zmode = 0;
    @(negedge clk); bus.din = d; bus.start = 1'b1;
    for (int c = 0; c < 4 * (W + 2) && dcyc.size() < 3; c++) begin
      @(negedge clk);
      if (bus.done) begin dcyc.push_back(c); douts.push_back(bus.dout); end
    end
    bus.start = 1'b0;
    total_cnt++;
    if (dcyc.size() != 3) $display("FAIL b2b_done_count got=%0d exp=3", dcyc.size());
    else pass_cnt++;
    if (dcyc.size() == 3) begin
      total_cnt++; if (dcyc[1] - dcyc[0] !== W + 2) $display("FAIL b2b_period got=%0d exp=%0d", dcyc[1] - dcyc[0], W + 2); else pass_cnt++;
      total_cnt++; if (dcyc[2] - dcyc[1] !== W + 2) $display("FAIL b2b_period2 got=%0d exp=%0d", dcyc[2] - dcyc[1], W + 2); else pass_cnt++;
      total_cnt++; if (douts[1] !== d) $display("FAIL b2b_dout got=%h exp=%h", douts[1], d); else pass_cnt++;
    end
    repeat (2 * (W + 2)) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_response_modes();
    test_start_ignored();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rom_fsm_stim_gen.md
# rom_fsm_stim_gen

- Serial stimulus/response engine for the ROM-table Mealy FSMs in this codebase.
- Takes a parallel word, drives it bit-serially onto the FSM input `X`, and captures the FSM's Mealy output `Z` once per bit into a parallel result word.
- Sits on the opposite side of the X/Z serial interface from the ROM FSM: it is the transmitter of `X` and the receiver of `Z`.
- Uses a start/ready/done handshake toward a host or bench sequencer.

## Interface
- `WIDTH`, default 8: bits per transfer; legal range 2..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request to begin a transfer; sampled only in IDLE.
- `din`  in  WIDTH  stimulus word; latched on the accepted `start` edge.
- `ready`  out  1  high only in IDLE; reset value 1.
- `busy`  out  1  high in SHIFT and DONE; reset value 0.
- `X`  out  1  serial stimulus to the FSM; registered; reset value 0.
- `Z`  in  1  FSM Mealy response; sampled on each SHIFT edge.
- `dout`  out  WIDTH  captured response word; updates only on the transfer's final edge; reset value 0.
- `done`  out  1  single-cycle completion pulse; reset value 0.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. The reset state is IDLE.
- IDLE:
  - `X`=0.
  - On an edge with `start`=1: `shreg`<=`din`, `cnt`<=0, `X`<=first bit, go to SHIFT.
  - With the macro undefined, the first bit is `din[WIDTH-1]`.
- SHIFT, every edge:
  - `cap` shifts in `Z`: `cap`<={`cap`[WIDTH-2:0], `Z`}.
  - If `cnt`==WIDTH-1: `dout`<=final `cap` (including the current `Z`), `done`<=1, `X`<=0, go to DONE.
  - Otherwise: `X`<=next stimulus bit, `cnt`<=`cnt`+1.
- DONE: `done`<=0, go to IDLE. `start` is ignored in this state.
- `start` is ignored whenever `ready`=0; `din` changes while busy have no effect.
- `cnt` has width clog2(WIDTH); it never wraps past WIDTH-1.
- `cap` is cleared to 0 on each accepted `start`.
- Reset asserted mid-transfer immediately forces all outputs to their reset values, returns to IDLE, and discards the partial capture. `dout` is cleared.
- With `Z` looped back to `X`, `dout` equals `din` in both bit orders.

## Timing
- Accepted `start` at edge k:
  - `X` carries bit 0 of the sequence during cycle k..k+1.
  - `Z` is sampled at edges k+1 through k+WIDTH.
  - `done` and the new `dout` are valid from edge k+WIDTH to k+WIDTH+1.
  - `ready` returns at edge k+WIDTH+1.
- `start`-to-`done` latency is WIDTH cycles. Minimum transfer period is WIDTH+2 cycles, because `start` is next accepted at edge k+WIDTH+2.
- `Z` must be settled before each sampling edge. It is a combinational function of `X` and the FSM state.
- A `start` held high continuously produces back-to-back transfers every WIDTH+2 cycles.

## Configuration
- Macro: `ROM_FSM_STIM_LSB_FIRST_EN`.
- Undefined: MSB-first.
  - Stimulus sequence is `din[WIDTH-1]` down to `din[0]`.
  - `Z` shifts into `cap` at the LSB (left shift).
- Defined: LSB-first.
  - Stimulus sequence is `din[0]` up to `din[WIDTH-1]`.
  - `cap` shifts right, with `Z` entering at `cap[WIDTH-1]`, so loopback still returns `dout`=`din`.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- Reset, then idle 3 cycles -> `ready`=1, `busy`=0, `X`=0, `done`=0, `dout`=0x00.
- WIDTH=8, `Z` tied to `X`, `din`=0xA5, `start` 1 cycle:
  - `X` sequence is 1,0,1,0,0,1,0,1.
  - `done` pulses exactly 8 cycles after the `start` edge; `dout`=0xA5.
  - `ready` is high 1 cycle after `done`.
- `Z` = ~`X`, `din`=0x3C -> `dout`=0xC3. Then `Z` tied 0, `din`=0xFF -> `dout`=0x00.
- `start` re-pulsed with `din`=0x11 at cycles 2 and 9 of a 0xA5 transfer -> both pulses ignored; `X` pattern and `dout`=0xA5 unchanged; exactly one `done`.
- `rst` asserted after 3 bits of a 0xF0 transfer -> asynchronously `X`=0, `busy`=0, `ready`=1, `dout`=0x00, no `done`. A following transfer of 0x0F completes with `dout`=0x0F.
- With `ROM_FSM_STIM_LSB_FIRST_EN` defined, loopback, `din`=0x01 -> `X` sequence 1,0,0,0,0,0,0,0; `dout`=0x01.
